// File: rtl/fifo_drain_ctrl_if.sv
// Signal bundle between the drain controller, its source FIFO and the downstream sink.
// The controller connects through master; the FIFO/sink environment through slave.
interface fifo_drain_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 5
);
    logic [DATA_W-1:0] fifo_data;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_fillcount;
    logic              fifo_get;
    logic              flush;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic              m_last;
    logic              busy;

    modport master (
        input  fifo_data, fifo_empty, fifo_fillcount, flush, m_ready,
        output fifo_get, m_data, m_valid, m_last, busy
    );

    modport slave (
        output fifo_data, fifo_empty, fifo_fillcount, flush, m_ready,
        input  fifo_get, m_data, m_valid, m_last, busy
    );
endinterface

// File: rtl/fifo_drain_ctrl.sv
// Drains a FIFO in bursts of up to BURST words onto a valid/ready stream,
// using a 2-entry skid buffer to cover the one-cycle FIFO read latency.
module fifo_drain_ctrl #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 5,
    parameter int BURST  = 4
) (
    input  logic              clk,
    input  logic              reset,
    fifo_drain_ctrl_if.master bus
);
    localparam logic [CNT_W-1:0] BURST_LEN = CNT_W'(BURST);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  remain;
    logic [CNT_W-1:0]  beats;
    logic [1:0]        occ;
    logic              inflight;
    logic [DATA_W-1:0] buf_mem [2];
    logic              rd_ptr;
    logic              wr_ptr;

    logic              get;
    logic              pop;
    logic              start;
    logic [CNT_W-1:0]  start_len;
    logic [2:0]        pending;
    logic [2:0]        limit;

    always_comb begin
        pop       = (occ != 2'd0) && bus.m_ready;
        // occ + inflight - pop < 2, rearranged to stay unsigned
        pending   = {1'b0, occ} + {2'b00, inflight};
        limit     = 3'd2 + {2'b00, pop};
        get       = (state == RUN) && (remain != '0) && !bus.fifo_empty && (pending < limit);
        start_len = (bus.fifo_fillcount >= BURST_LEN) ? BURST_LEN : bus.fifo_fillcount;
        // A zero-length flush burst could never complete, so it is not started
        start     = (state == IDLE) &&
                    ((bus.fifo_fillcount >= BURST_LEN) ||
                     (bus.flush && !bus.fifo_empty && (bus.fifo_fillcount != '0)));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            remain   <= '0;
            beats    <= '0;
            occ      <= 2'd0;
            inflight <= 1'b0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
            for (int unsigned i = 0; i < 2; i++) begin
                buf_mem[i] <= '0;
            end
        end else begin
            inflight <= get;

            if (inflight) begin
                buf_mem[wr_ptr] <= bus.fifo_data;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end

            case ({inflight, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase

            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= RUN;
                        remain <= start_len;
                        beats  <= start_len;
                    end
                end
                RUN: begin
                    if (get) begin
                        remain <= remain - 1'b1;
                    end
                    if (pop && (beats != '0)) begin
                        beats <= beats - 1'b1;
                        if (beats == CNT_W'(1)) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.fifo_get = get;
    assign bus.m_valid  = (occ != 2'd0);
    assign bus.m_data   = buf_mem[rd_ptr];
    assign bus.m_last   = (occ != 2'd0) && (beats == CNT_W'(1));
    assign bus.busy     = (state == RUN);

    a_no_overflow : assert property (@(posedge clk) disable iff (!reset)
        inflight |-> ((occ != 2'd2) || pop));
    a_occ_range : assert property (@(posedge clk) disable iff (!reset)
        occ != 2'd3);
    a_no_extra_beat : assert property (@(posedge clk) disable iff (!reset)
        pop |-> (beats != '0));
endmodule
